// File: rtl/posit_norm_encoder_pkg.sv
// Shared types and constants for the posit normalise/encode back end.
// Also holds the stage-advance rule used by every pipeline stage.
package posit_norm_encoder_pkg;

  typedef enum logic {
    POS = 1'b0,
    NEG = 1'b1
  } sign_t;

  localparam int POSIT_N  = 8;
  localparam int POSIT_ES = 1;

  localparam logic [POSIT_N-1:0] NAR    = 8'h80;
  localparam logic [POSIT_N-1:0] MAXPOS = 8'h7F;
  localparam logic [POSIT_N-1:0] MINPOS = 8'h01;

  // A stage may load when it is empty or its current beat moves on.
  function automatic logic stage_advance(input logic valid, input logic next_advance);
    return !valid || next_advance;
  endfunction

endpackage

// File: rtl/posit_norm_encoder_lod8.sv
// 8-bit leading-one detector: position of the highest set bit and a zero flag.
module posit_norm_encoder_lod8 (
  input  logic [7:0] value,
  output logic [2:0] pos,
  output logic       zero
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    pos  = 3'd0;
    zero = (value == 8'd0);
    for (int i = 0; i < 8; i++) begin
      if (value[i]) pos = 3'(i);
    end
  end

endmodule

// File: rtl/posit_norm_encoder.sv
// Three-stage valid/ready normaliser and posit packer for the posit add path.
// Define POSIT_RNE_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module posit_norm_encoder
  import posit_norm_encoder_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  sign_t        in_sign,
  input  logic [7:0]   in_regime,
  input  logic [7:0]   in_exponent,
  input  logic [7:0]   in_mantissa,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_posit,
  output logic         out_sat
);

  localparam int                FRAC_W   = 7;
  localparam int                STREAM_W = 1 + ES + FRAC_W + N;
  localparam logic signed [9:0] R_MAX    = 10'(N - 2);
  localparam logic signed [9:0] R_MIN    = -R_MAX;
  localparam logic [N-1:0]      MAX_MAG  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]      MIN_MAG  = N'(1);

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, s3_adv;

  assign s3_adv   = stage_advance(out_valid, out_ready);
  assign s2_adv   = stage_advance(s2_valid, s3_adv);
  assign s1_adv   = stage_advance(s1_valid, s2_adv);
  assign in_ready = s1_adv;

  // ---------------- Stage 1: leading-one detect and scale ----------------
  logic [2:0]        lod_pos;
  logic              lod_zero;
  logic signed [9:0] k_comb, s_comb;

  posit_norm_encoder_lod8 u_lod8 (
    .value (in_mantissa),
    .pos   (lod_pos),
    .zero  (lod_zero)
  );

  always_comb begin
    k_comb = ({{2{in_regime[7]}}, in_regime} << ES) + {{2{in_exponent[7]}}, in_exponent};
    s_comb = k_comb - 10'sd6 + {7'd0, lod_pos};
  end

  sign_t             s1_sign;
  logic              s1_zero;
  logic signed [9:0] s1_s;
  logic [7:0]        s1_mantissa;
  logic [2:0]        s1_p;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    if (rst)         s1_valid <= 1'b0;
    else if (s1_adv) s1_valid <= in_valid;
  end

  // NOTE: datapath registers carry no reset; the stage valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_sign     <= in_sign;
      s1_zero     <= lod_zero;
      s1_s        <= s_comb;
      s1_mantissa <= in_mantissa;
      s1_p        <= lod_pos;
    end
  end

  // ---------------- Stage 2: regime/exponent split and bitstream build ----------------
  logic signed [9:0]   r_comb, run;
  logic                run_bit;
  logic [ES-1:0]       e_comb;
  logic [FRAC_W-1:0]   frac;
  logic [STREAM_W-1:0] stream, shifted;

  // The terminator, exponent and fraction are shifted right by the run length,
  // with the vacated top filled by the run bit.
  always_comb begin
    r_comb  = s1_s >>> ES;
    e_comb  = s1_s[ES-1:0];
    frac    = FRAC_W'(s1_mantissa << (3'd7 - s1_p));
    run_bit = !r_comb[9];
    run     = run_bit ? r_comb + 10'sd1 : -r_comb;
    stream  = {!run_bit, e_comb, frac, {N{1'b0}}};
    shifted = (stream >> run) | (run_bit ? ~({STREAM_W{1'b1}} >> run) : '0);
  end

  sign_t        s2_sign;
  logic         s2_zero;
  logic         s2_sat_max, s2_sat_min;
  logic [N-2:0] s2_mag;
`ifdef POSIT_RNE_EN
  logic         s2_guard, s2_sticky;
`else
  logic         unused_tail;
  assign unused_tail = ^shifted[STREAM_W-N:0];
`endif

  always_ff @(posedge clk) begin
    if (rst)         s2_valid <= 1'b0;
    else if (s2_adv) s2_valid <= s1_valid;
  end

  always_ff @(posedge clk) begin
    if (s2_adv && s1_valid) begin
      s2_sign    <= s1_sign;
      s2_zero    <= s1_zero;
      s2_sat_max <= (r_comb >= R_MAX);
      s2_sat_min <= (r_comb < R_MIN);
      s2_mag     <= shifted[STREAM_W-1 -: N-1];
`ifdef POSIT_RNE_EN
      s2_guard   <= shifted[STREAM_W-N];
      s2_sticky  <= |shifted[STREAM_W-N-1:0];
`endif
    end
  end

  // ---------------- Stage 3: round, saturate, apply sign ----------------
  logic [N-1:0] mag, posit_next;
  logic         sat_next;

  always_comb begin
    mag      = {1'b0, s2_mag};
    sat_next = 1'b0;
`ifdef POSIT_RNE_EN
    if (s2_guard && (s2_sticky || s2_mag[0])) mag = mag + N'(1);
`endif
    // Saturation overrides any rounding; a carry into the sign bit clamps to maxpos.
    if (s2_sat_max) begin
      mag      = MAX_MAG;
      sat_next = 1'b1;
    end else if (s2_sat_min) begin
      mag      = MIN_MAG;
      sat_next = 1'b1;
    end else if (mag[N-1]) begin
      mag      = MAX_MAG;
      sat_next = 1'b1;
    end

    if (s2_zero) begin
      posit_next = '0;
      sat_next   = 1'b0;
    end else if (s2_sign == NEG) begin
      posit_next = -mag;
    end else begin
      posit_next = mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= '0;
      out_sat   <= 1'b0;
    end else if (s3_adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_posit <= posit_next;
        out_sat   <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_posit_norm_encoder.sv
// Self-checking bench for posit_norm_encoder (N=8, ES=1): spec vectors, random stream
// against a bit-list posit model, backpressure and mid-stream reset sequences.
module tb_posit_norm_encoder;
  import posit_norm_encoder_pkg::*;

  typedef struct {
    sign_t      sign;
    int         regime;
    int         expo;
    int         mant;
    logic [7:0] posit;
    logic       sat;
  } vec_t;

  typedef struct {
    logic [7:0] posit;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  sign_t      in_sign = POS;
  logic [7:0] in_regime = 8'd0;
  logic [7:0] in_exponent = 8'd0;
  logic [7:0] in_mantissa = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_posit;
  logic       out_sat;

  always #5 clk = ~clk;

  posit_norm_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_regime   (in_regime),
    .in_exponent (in_exponent),
    .in_mantissa (in_mantissa),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_posit   (out_posit),
    .out_sat     (out_sat)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_out    = 0;
  exp_t       exp_q[$];
  logic [7:0] nx_posit;
  logic       nx_sat;
  logic       f;
  vec_t       vecs[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Posit encoding from first principles: magnitude = m * 2^(k-6), written out as a
  // list of bits (regime run, terminator, exponent, fraction) and cut to 7 bits.
  function automatic void ref_model(input sign_t sg, input int regime, input int expo,
                                    input int m, output logic [7:0] posit, output logic sat);
    int p, s, r, e, mag;
    bit q[$];
`ifdef POSIT_RNE_EN
    bit guard, sticky;
`endif
    if (m == 0) begin
      posit = 8'h00;
      sat   = 1'b0;
      return;
    end
    p = 0;
    for (int i = 0; i < 8; i++) if (((m >> i) & 1) != 0) p = i;
    s = regime * 2 + expo - 6 + p;
    r = (s >= 0) ? s / 2 : -((1 - s) / 2);
    e = s - 2 * r;
    sat = 1'b0;
    if (r >= 6) begin
      mag = 127;
      sat = 1'b1;
    end else if (r < -6) begin
      mag = 1;
      sat = 1'b1;
    end else begin
      if (r >= 0) begin
        repeat (r + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-r) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[0]);
      for (int i = p - 1; i >= 0; i--) q.push_back(((m >> i) & 1) != 0);
      while (q.size() < 9) q.push_back(1'b0);
      mag = 0;
      for (int i = 0; i < 7; i++) mag = mag * 2 + int'(q[i]);
`ifdef POSIT_RNE_EN
      guard  = q[7];
      sticky = 1'b0;
      for (int i = 8; i < q.size(); i++) sticky |= q[i];
      if (guard && (sticky || (mag % 2 == 1))) mag++;
      if (mag > 127) begin
        mag = 127;
        sat = 1'b1;
      end
`endif
    end
    posit = (sg == NEG) ? 8'(-mag) : 8'(mag);
  endfunction

  task automatic drive(input sign_t sg, input int rg, input int ex, input int m,
                       input logic [7:0] ep, input logic es);
    in_valid    = 1'b1;
    in_sign     = sg;
    in_regime   = 8'(rg);
    in_exponent = 8'(ex);
    in_mantissa = 8'(m);
    nx_posit    = ep;
    nx_sat      = es;
  endtask

  task automatic drive_model(input sign_t sg, input int rg, input int ex, input int m);
    logic [7:0] ep;
    logic       es;
    ref_model(sg, rg, ex, m, ep, es);
    drive(sg, rg, ex, m, ep, es);
  endtask

  // One clock: record handshakes just before the edge, score any emitted beat.
  task automatic step(output logic fired_in);
    exp_t e;
    #1;
    fired_in = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      check("beat_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("posit", int'(out_posit), int'(e.posit));
        check("sat", int'(out_sat), int'(e.sat));
        if (e.posit != 8'h00) check("not_nar", int'(out_posit != NAR), 1);
      end
    end
    if (fired_in) exp_q.push_back('{posit: nx_posit, sat: nx_sat});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(f);
    check(name, exp_q.size(), 0);
  endtask

  task automatic add_vec(input sign_t sg, input int rg, input int ex, input int m,
                         input logic [7:0] ep, input logic es);
    vecs.push_back('{sign: sg, regime: rg, expo: ex, mant: m, posit: ep, sat: es});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_posit", int'(out_posit), 0);
    check("rst_out_sat", int'(out_sat), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Latency: accepted on the first edge, visible after the third
    drive_model(POS, 0, 0, 'h40);
    step(f);
    in_valid = 1'b0;
    check("lat_accept", int'(f), 1);
    check("lat_c1", int'(out_valid), 0);
    step(f);
    check("lat_c2", int'(out_valid), 0);
    step(f);
    check("lat_c3", int'(out_valid), 1);
    check("lat_posit", int'(out_posit), 'h40);
    drain("lat_drain");

    // Spec vectors
    add_vec(POS, 0, 0, 'h40, 8'h40, 1'b0);
    add_vec(POS, 0, 0, 'h80, 8'h50, 1'b0);
    add_vec(POS, 0, 0, 'h60, 8'h48, 1'b0);
    add_vec(NEG, 0, 0, 'h60, 8'hB8, 1'b0);
    add_vec(POS, 0, 0, 'h42, 8'h40, 1'b0);
`ifdef POSIT_RNE_EN
    add_vec(POS, 0, 0, 'h43, 8'h41, 1'b0);
    add_vec(POS, 5, 1, 'h41, 8'h7F, 1'b0);
`else
    add_vec(POS, 0, 0, 'h43, 8'h40, 1'b0);
    add_vec(POS, 5, 1, 'h41, 8'h7E, 1'b0);
`endif
    add_vec(POS, 1, 1, 'h40, 8'h68, 1'b0);
    add_vec(POS, -1, 0, 'h40, 8'h20, 1'b0);
    add_vec(POS, 7, 0, 'h40, MAXPOS, 1'b1);
    add_vec(POS, -7, 0, 'h40, MINPOS, 1'b1);
    add_vec(NEG, 7, 0, 'h40, 8'h81, 1'b1);
    add_vec(NEG, -7, 0, 'h40, 8'hFF, 1'b1);
    add_vec(POS, 3, 0, 'h00, 8'h00, 1'b0);
    add_vec(NEG, -5, 1, 'h00, 8'h00, 1'b0);
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].sign, vecs[i].regime, vecs[i].expo, vecs[i].mant, vecs[i].posit, vecs[i].sat);
      f = 1'b0;
      for (int c = 0; c < 10 && !f; c++) step(f);
      check("vec_accept", int'(f), 1);
    end
    drain("vec_drain");

    // Backpressure: four back-to-back beats against a stalled output
    out_ready = 1'b0;
    n_out = 0;
    drive_model(POS, 0, 0, 'h40);
    #1 check("bp_ready0", int'(in_ready), 1);
    step(f);
    drive_model(POS, 0, 0, 'h60);
    #1 check("bp_ready1", int'(in_ready), 1);
    step(f);
    drive_model(POS, 0, 0, 'h80);
    #1 check("bp_ready2", int'(in_ready), 1);
    step(f);
    drive_model(NEG, 0, 0, 'h60);
    #1 check("bp_stall_ready", int'(in_ready), 0);
    for (int c = 0; c < 5; c++) begin
      step(f);
      check("bp_no_accept", int'(f), 0);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_posit", int'(out_posit), 'h40);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n_out < 4; c++) begin
      step(f);
      if (f) in_valid = 1'b0;
    end
    check("bp_count", n_out, 4);
    drain("bp_drain");

    // Random stream with random backpressure against the model
    for (int c = 0; c < 400; c++) begin
      logic       hold;
      logic [7:0] held_posit;
      logic       held_sat;
      if ($urandom_range(0, 9) < 7)
        drive_model($urandom_range(0, 1) ? NEG : POS, int'($urandom_range(0, 18)) - 9,
                    int'($urandom_range(0, 3)) - 1,
                    ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)));
      else
        in_valid = 1'b0;
      out_ready  = ($urandom_range(0, 9) < 7);
      #1;
      hold       = out_valid && !out_ready;
      held_posit = out_posit;
      held_sat   = out_sat;
      step(f);
      if (hold) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_posit", int'(out_posit), int'(held_posit));
        check("stall_sat", int'(out_sat), int'(held_sat));
      end
    end
    drain("rand_drain");

    // Reset mid-stream discards everything in flight
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive_model(POS, b, 0, 'h40);
      step(f);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(f);
      check("mid_rst_no_beat", int'(out_valid), 0);
    end
    check("mid_rst_ready", int'(in_ready), 1);
    drive_model(NEG, 0, 0, 'h80);
    step(f);
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
